// File: rtl/equiv_monitor.sv
// Equivalence monitor: waits a settle window after each stimulus change, then
// compares a reference value against a DUT value bit-for-bit (4-state) and keeps stats.
module equiv_monitor #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             stim_chg,
    input  logic [WIDTH-1:0] ref_val,
    input  logic [WIDTH-1:0] dut_val,
    output logic             cmp_valid,
    output logic             cmp_same,
    output logic             busy,
    output logic             sticky_fail,
    output logic [CNT_W-1:0] compare_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // SETTLE is at most 15, so the window counter never needs more than 4 bits.
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_do_cmp;
    logic             w_same;

    logic             r_cmp_valid;
    logic             r_cmp_same;
    logic             r_sticky;
    logic [CNT_W-1:0] r_compare_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_do_cmp    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (stim_chg) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = RELOAD;
                end
            end
            ST_SETTLE: begin
                // A new stimulus change restarts the window rather than comparing stale values.
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (stim_chg) begin
                    w_cnt_nxt = RELOAD;
                end else if (r_cnt == 4'd0) begin
                    w_do_cmp    = 1'b1;
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Case equality so that X/Z bits must match exactly, not merely resolve to equal values.
    assign w_same = (ref_val === dut_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_valid    <= 1'b0;
            r_cmp_same     <= 1'b1;
            r_sticky       <= 1'b0;
            r_compare_cnt  <= '0;
            r_mismatch_cnt <= '0;
        end else begin
            r_cmp_valid <= w_do_cmp;
            if (w_do_cmp) begin
                r_cmp_same <= w_same;
            end
            // clr outranks the statistics update of a coincident compare.
            if (clr) begin
                r_sticky       <= 1'b0;
                r_compare_cnt  <= '0;
                r_mismatch_cnt <= '0;
            end else if (w_do_cmp) begin
                if (r_compare_cnt != '1) begin
                    r_compare_cnt <= r_compare_cnt + 1'b1;
                end
                if (!w_same) begin
                    r_sticky <= 1'b1;
                    if (r_mismatch_cnt != '1) begin
                        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign cmp_valid    = r_cmp_valid;
    assign cmp_same     = r_cmp_same;
    assign busy         = (r_state == ST_SETTLE);
    assign sticky_fail  = r_sticky;
    assign compare_cnt  = r_compare_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_equiv_monitor.sv
// Bench for equiv_monitor: hand-derived vector table, corner sequences and a
// random phase, all checked against a deadline-based reference model.
module tb_equiv_monitor;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             stim_chg = 1'b0;
    logic [WIDTH-1:0] ref_val = '0;
    logic [WIDTH-1:0] dut_val = '0;

    logic       cmp_valid, cmp_same, busy, sticky_fail;
    logic [7:0] compare_cnt, mismatch_cnt;
    logic [1:0] dbg_state;

    logic       s_cmp_valid, s_cmp_same, s_busy, s_sticky_fail;
    logic [1:0] s_compare_cnt, s_mismatch_cnt;
    logic [1:0] s_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    equiv_monitor #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .stim_chg(stim_chg),
        .ref_val(ref_val), .dut_val(dut_val),
        .cmp_valid(cmp_valid), .cmp_same(cmp_same), .busy(busy),
        .sticky_fail(sticky_fail), .compare_cnt(compare_cnt),
        .mismatch_cnt(mismatch_cnt), .o_dbg_state(dbg_state)
    );

    // Narrow-counter instance shares all inputs so saturation is seen on the same traffic.
    equiv_monitor #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .stim_chg(stim_chg),
        .ref_val(ref_val), .dut_val(dut_val),
        .cmp_valid(s_cmp_valid), .cmp_same(s_cmp_same), .busy(s_busy),
        .sticky_fail(s_sticky_fail), .compare_cnt(s_compare_cnt),
        .mismatch_cnt(s_mismatch_cnt), .o_dbg_state(s_dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: a pending compare is due SETTLE edges after the last accepted change.
    int   m_cycle = 0;
    int   m_deadline = 0;
    bit   m_active = 0;
    bit   m_pending = 0;
    logic m_valid = 1'b0;
    logic m_same = 1'b1;
    logic m_sticky = 1'b0;
    int   m_total = 0;
    int   m_mis = 0;

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic model_update();
        m_cycle++;
        m_valid = 1'b0;
        if (rst) begin
            m_active = 0; m_pending = 0; m_same = 1'b1;
            m_total = 0; m_mis = 0; m_sticky = 1'b0;
        end else begin
            if (!en) begin
                m_active = 0; m_pending = 0;
            end else if (!m_active) begin
                m_active = 1;
            end else if (stim_chg) begin
                m_pending = 1;
                m_deadline = m_cycle + SETTLE;
            end else if (m_pending && m_cycle == m_deadline) begin
                m_pending = 0;
                m_valid = 1'b1;
                m_same = (ref_val === dut_val);
                m_total++;
                if (!m_same) begin
                    m_mis++;
                    m_sticky = 1'b1;
                end
            end
            if (clr) begin
                m_total = 0; m_mis = 0; m_sticky = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, m_cycle);
        end
    endtask

    task automatic check_model();
        int exp_state;
        exp_state = !m_active ? 0 : (m_pending ? 2 : 1);
        check("cmp_valid",   32'(cmp_valid),    32'(m_valid));
        check("cmp_same",    32'(cmp_same),     32'(m_same));
        check("busy",        32'(busy),         32'(m_pending));
        check("sticky_fail", 32'(sticky_fail),  32'(m_sticky));
        check("compare_cnt", 32'(compare_cnt),  32'(sat(m_total, 255)));
        check("mismatch_cnt",32'(mismatch_cnt), 32'(sat(m_mis, 255)));
        check("state",       32'(dbg_state),    32'(exp_state));
        check("sat_valid",   32'(s_cmp_valid),  32'(m_valid));
        check("sat_sticky",  32'(s_sticky_fail),32'(m_sticky));
        check("sat_cmp_cnt", 32'(s_compare_cnt),32'(sat(m_total, 3)));
        check("sat_mis_cnt", 32'(s_mismatch_cnt),32'(sat(m_mis, 3)));
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic s,
                        input logic [WIDTH-1:0] rv, input logic [WIDTH-1:0] dv);
        @(negedge clk);
        rst = r; en = e; clr = c; stim_chg = s; ref_val = rv; dut_val = dv;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    typedef struct {
        logic rst, en, clr, stim;
        logic [WIDTH-1:0] rv, dv;
        logic e_valid, e_same, e_busy, e_sticky;
        int   e_cnt, e_mis, e_state;
    } vec_t;

    vec_t tbl[31];

    initial begin
        // Fields: rst en clr stim ref dut | valid same busy sticky cmp_cnt mis_cnt state
        tbl[0]  = '{1,0,0,0, 0,0, 0,1,0,0, 0,0,0};
        tbl[1]  = '{0,1,0,0, 0,0, 0,1,0,0, 0,0,1};
        tbl[2]  = '{0,1,0,1, 0,0, 0,1,1,0, 0,0,2};
        tbl[3]  = '{0,1,0,0, 0,0, 0,1,1,0, 0,0,2};
        tbl[4]  = '{0,1,0,0, 0,0, 1,1,0,0, 1,0,1};
        tbl[5]  = '{0,1,0,0, 0,0, 0,1,0,0, 1,0,1};
        tbl[6]  = '{0,1,0,1, 0,0, 0,1,1,0, 1,0,2};
        tbl[7]  = '{0,1,0,0, 0,0, 0,1,1,0, 1,0,2};
        tbl[8]  = '{0,1,0,0, 0,5, 1,0,0,1, 2,1,1};
        tbl[9]  = '{0,1,0,0, 0,0, 0,0,0,1, 2,1,1};
        tbl[10] = '{0,1,0,1, 0,0, 0,0,1,1, 2,1,2};
        tbl[11] = '{0,1,0,0, 0,0, 0,0,1,1, 2,1,2};
        tbl[12] = '{0,1,0,0, 3,3, 1,1,0,1, 3,1,1};
        tbl[13] = '{0,1,0,1, 0,0, 0,1,1,1, 3,1,2};
        tbl[14] = '{0,1,0,1, 0,0, 0,1,1,1, 3,1,2};
        tbl[15] = '{0,1,0,0, 0,0, 0,1,1,1, 3,1,2};
        tbl[16] = '{0,1,0,0, 7,7, 1,1,0,1, 4,1,1};
        tbl[17] = '{0,1,0,1, 0,0, 0,1,1,1, 4,1,2};
        tbl[18] = '{0,0,0,0, 0,0, 0,1,0,1, 4,1,0};
        tbl[19] = '{0,0,0,0, 1,2, 0,1,0,1, 4,1,0};
        tbl[20] = '{0,1,0,1, 0,0, 0,1,0,1, 4,1,1};
        tbl[21] = '{0,1,0,1, 0,0, 0,1,1,1, 4,1,2};
        tbl[22] = '{0,1,0,0, 0,0, 0,1,1,1, 4,1,2};
        tbl[23] = '{0,1,1,0, 1,2, 1,0,0,0, 0,0,1};
        tbl[24] = '{0,1,0,0, 0,0, 0,0,0,0, 0,0,1};
        tbl[25] = '{0,1,0,1, 0,0, 0,0,1,0, 0,0,2};
        tbl[26] = '{0,1,0,0, 0,0, 0,0,1,0, 0,0,2};
        tbl[27] = '{0,1,0,0, 1,0, 1,0,0,1, 1,1,1};
        tbl[28] = '{0,1,0,1, 0,0, 0,0,1,1, 1,1,2};
        tbl[29] = '{1,1,0,0, 0,0, 0,1,0,0, 0,0,0};
        tbl[30] = '{0,1,0,0, 5,6, 0,1,0,0, 0,0,1};

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].stim, tbl[i].rv, tbl[i].dv);
            check($sformatf("tbl%0d_valid", i),  32'(cmp_valid),    32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_same", i),   32'(cmp_same),     32'(tbl[i].e_same));
            check($sformatf("tbl%0d_busy", i),   32'(busy),         32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_sticky", i), 32'(sticky_fail),  32'(tbl[i].e_sticky));
            check($sformatf("tbl%0d_cnt", i),    32'(compare_cnt),  32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_mis", i),    32'(mismatch_cnt), 32'(tbl[i].e_mis));
            check($sformatf("tbl%0d_state", i),  32'(dbg_state),    32'(tbl[i].e_state));
        end

        // Five mismatching compares after a clear: narrow counters pin at 3.
        step(0, 1, 1, 0, 4'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 1, 4'h0, 4'h0);
            step(0, 1, 0, 0, 4'h0, 4'h0);
            step(0, 1, 0, 0, 4'h0, 4'hf);
        end
        check("sat_seq_cmp_cnt", 32'(s_compare_cnt),  32'd3);
        check("sat_seq_mis_cnt", 32'(s_mismatch_cnt), 32'd3);
        check("sat_seq_sticky",  32'(s_sticky_fail),  32'd1);
        check("wide_seq_mis_cnt",32'(mismatch_cnt),   32'd5);

        // Unknown bits on the DUT side at the compare edge, then a clean match.
        step(0, 1, 1, 0, 4'h0, 4'h0);
        step(0, 1, 0, 1, 4'h0, 4'h0);
        step(0, 1, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 0, 4'h0, 4'bxxxx);
        step(0, 1, 0, 1, 4'h0, 4'h0);
        step(0, 1, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 0, 4'h9, 4'h9);

        for (int n = 0; n < 600; n++) begin
            logic r, e, c, s;
            logic [WIDTH-1:0] rv, dv;
            r  = ($urandom_range(63) == 0);
            e  = ($urandom_range(9) != 0);
            c  = ($urandom_range(31) == 0);
            s  = ($urandom_range(2) == 0);
            rv = WIDTH'($urandom);
            dv = ($urandom_range(1) == 0) ? rv : WIDTH'($urandom);
            step(r, e, c, s, rv, dv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
